// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs,
// ALU operation codes, datapath mux selects and the FSM state type.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [3:0] ALU_ADD = 4'b1000;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMMSL2 = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// R-type funct field to ALU operation code; valid=0 for unsupported functs.
module alu_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_ctr,
  output logic       valid
);

  // Pure lookup; unsupported functs fall back to ADD with valid low
  always_comb begin
    alu_ctr = ALU_ADD;
    valid   = 1'b1;
    case (funct)
      FN_ADD:  alu_ctr = ALU_ADD;
      FN_SUB:  alu_ctr = ALU_SUB;
      FN_AND:  alu_ctr = ALU_AND;
      FN_OR:   alu_ctr = ALU_OR;
      FN_SLT:  alu_ctr = ALU_SLT;
      FN_NOR:  alu_ctr = ALU_NOR;
      default: valid   = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: one state per cycle from FETCH to writeback,
// memory stalls on mem_ready with a bounded wait, retired-instruction count.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_re,
  output logic             mem_we,
  output logic             ir_we,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [3:0]       alu_ctr,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned       WAIT_W    = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        dec_alu_ctr;
  logic              dec_valid;
  logic              in_mem, stalled, timeout, retire;

  alu_op_decode u_alu_op_decode (
    .funct   (funct),
    .alu_ctr (dec_alu_ctr),
    .valid   (dec_valid)
  );

  // Consecutive mem_ready-low cycles in a memory state; the TIMEOUT-th one aborts
  always_comb begin
    in_mem  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    stalled = in_mem && !mem_ready;
    timeout = stalled && (wait_q == WAIT_LAST);
    wait_d  = (stalled && !timeout) ? wait_q + WAIT_W'(1) : '0;
  end

  // Next state and datapath controls; all enables forced low while in reset
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PCSRC_ALU;
    iord       = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_RT;
    alu_ctr    = ALU_ADD;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = SRCB_FOUR;
        if (timeout) begin
          bus_err = 1'b1;
        end else begin
          mem_re = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSL2;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (timeout) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          mem_re = 1'b1;
          if (mem_ready) state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord = 1'b1;
        if (timeout) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          mem_we = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_EXEC: begin
        alusrca = 1'b1;
        alu_ctr = dec_alu_ctr;
        if (dec_valid) begin
          state_d = S_ALUWB;
        end else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_ALUWB: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        alu_ctr = ALU_SUB;
        pc_src  = PCSRC_ALUOUT;
        pc_we   = alu_zero;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = PCSRC_JUMP;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (!rst_n) begin
      pc_we   = 1'b0;
      mem_re  = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      illegal = 1'b0;
      bus_err = 1'b0;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_comb begin
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // State, wait counter and retire counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed table, hand sequences for
// reset/timeout/wrap, and random instructions against an instruction-level model.
module tb_multicycle_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MOD = 1 << CNT_W;
  localparam int TO      = 3;

  localparam logic [5:0] C_R = 6'b000000, C_LW = 6'b100011, C_SW = 6'b101011;
  localparam logic [5:0] C_BEQ = 6'b000100, C_ADDI = 6'b001000, C_J = 6'b000010;
  localparam logic [3:0] A_ADD = 4'b1000, A_SUB = 4'b0110;

  logic clk, rst_n, alu_zero, mem_ready;
  logic [5:0] op, funct;
  logic pc_we, iord, mem_re, mem_we, ir_we, reg_we, reg_dst, mem_to_reg, alusrca;
  logic illegal, bus_err;
  logic [1:0] pc_src, alusrcb;
  logic [3:0] alu_ctr;
  logic [CNT_W-1:0] instr_cnt;

  multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .pc_src(pc_src), .iord(iord),
    .mem_re(mem_re), .mem_we(mem_we), .ir_we(ir_we), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alusrca(alusrca),
    .alusrcb(alusrcb), .alu_ctr(alu_ctr), .illegal(illegal), .bus_err(bus_err),
    .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic pc_we; logic [1:0] pc_src; logic iord; logic mem_re; logic mem_we;
    logic ir_we; logic reg_we; logic reg_dst; logic mem_to_reg; logic alusrca;
    logic [1:0] alusrcb; logic [3:0] alu_ctr; logic illegal; logic bus_err;
  } ctl_t;

  typedef struct { logic rdy; ctl_t val; ctl_t care; } step_t;

  typedef struct {
    logic [5:0] op; logic [5:0] funct; logic zero; logic [7:0] rdy; int lat;
    logic [4:0] en;        // {pc_we, mem_we, reg_we, illegal, bus_err} in last cycle
    logic [3:0] sel;       // {pc_src, reg_dst, mem_to_reg} in last cycle
    logic [3:0] sel_care;
    int dcnt;
  } vec_t;

  int n_vec = 0, n_bad = 0, cnt_model = 0;
  step_t exp_q[$];
  ctl_t v, c;
  logic [5:0] fn_tab [6];
  logic [3:0] alu_tab[6];

  function automatic ctl_t get_act();
    return {pc_we, pc_src, iord, mem_re, mem_we, ir_we, reg_we, reg_dst,
            mem_to_reg, alusrca, alusrcb, alu_ctr, illegal, bus_err};
  endfunction

  task automatic chk_ctl(input string nm, input ctl_t val, input ctl_t care);
    ctl_t act;
    act = get_act();
    n_vec++;
    if (((act ^ val) & care) != '0) begin
      n_bad++;
      $display("FAIL %s: got %h want %h mask %h", nm, act, val, care);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  task automatic clr();
    v = '0; c = '0;
    c.pc_we = 1; c.mem_re = 1; c.mem_we = 1; c.ir_we = 1; c.reg_we = 1;
    c.illegal = 1; c.bus_err = 1;
  endtask
  task automatic s_a(input logic x);        v.alusrca = x;    c.alusrca = 1;    endtask
  task automatic s_b(input logic [1:0] x);  v.alusrcb = x;    c.alusrcb = '1;   endtask
  task automatic s_alu(input logic [3:0] x); v.alu_ctr = x;   c.alu_ctr = '1;   endtask
  task automatic s_pcs(input logic [1:0] x); v.pc_src = x;    c.pc_src = '1;    endtask
  task automatic s_io(input logic x);       v.iord = x;       c.iord = 1;       endtask
  task automatic s_wb(input logic dst, input logic m2r);
    v.reg_we = 1; v.reg_dst = dst; c.reg_dst = 1; v.mem_to_reg = m2r; c.mem_to_reg = 1;
  endtask
  task automatic push(input logic rdy);
    step_t s;
    s.rdy = rdy; s.val = v; s.care = c;
    exp_q.push_back(s);
  endtask

  // kind: 0 fetch, 1 read, 2 write. Returns ok=0 when the wait hits TIMEOUT.
  task automatic mem_phase(input int kind, input int waits, output bit ok);
    for (int k = 1; k <= waits + 1; k++) begin
      bit done;
      done = (k == waits + 1);
      clr();
      if (!done && k == TO) begin
        v.bus_err = 1; push(1'b0); ok = 0; return;
      end
      if (kind == 0) begin
        v.mem_re = 1; s_io(0); s_a(0); s_b(2'd1); s_alu(A_ADD);
        if (done) begin v.ir_we = 1; v.pc_we = 1; s_pcs(2'd0); end
      end else begin
        s_io(1);
        if (kind == 1) v.mem_re = 1; else v.mem_we = 1;
      end
      push(done);
    end
    ok = 1;
  endtask

  task automatic alu_lookup(input logic [5:0] f, output bit ok, output logic [3:0] a);
    ok = 0; a = '0;
    for (int i = 0; i < 6; i++) if (fn_tab[i] == f) begin ok = 1; a = alu_tab[i]; end
  endtask

  task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input int fw, input int mw, output bit retire);
    bit ok, known;
    logic [3:0] a;
    exp_q.delete();
    retire = 0;
    mem_phase(0, fw, ok);
    if (!ok) return;
    known = (o == C_R) || (o == C_LW) || (o == C_SW) || (o == C_BEQ) ||
            (o == C_ADDI) || (o == C_J);
    clr(); s_a(0); s_b(2'd3); s_alu(A_ADD);
    if (!known) begin v.illegal = 1; push(1'($urandom_range(0, 1))); return; end
    push(1'($urandom_range(0, 1)));
    if (o == C_LW || o == C_SW) begin
      clr(); s_a(1); s_b(2'd2); s_alu(A_ADD); push(1'($urandom_range(0, 1)));
      mem_phase((o == C_LW) ? 1 : 2, mw, ok);
      if (!ok) return;
      if (o == C_LW) begin clr(); s_wb(0, 1); push(1'($urandom_range(0, 1))); end
    end else if (o == C_R) begin
      alu_lookup(f, ok, a);
      clr(); s_a(1); s_b(2'd0);
      if (ok) s_alu(a); else v.illegal = 1;
      push(1'($urandom_range(0, 1)));
      if (!ok) return;
      clr(); s_wb(1, 0); push(1'($urandom_range(0, 1)));
    end else if (o == C_BEQ) begin
      clr(); s_a(1); s_b(2'd0); s_alu(A_SUB); s_pcs(2'd1); v.pc_we = z;
      push(1'($urandom_range(0, 1)));
    end else if (o == C_J) begin
      clr(); s_pcs(2'd2); v.pc_we = 1; push(1'($urandom_range(0, 1)));
    end else begin
      clr(); s_a(1); s_b(2'd2); s_alu(A_ADD); push(1'($urandom_range(0, 1)));
      clr(); s_wb(0, 0); push(1'($urandom_range(0, 1)));
    end
    retire = 1;
  endtask

  // Called at posedge+1 with the DUT in FETCH; leaves at posedge+1.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int fw, input int mw);
    bit ret;
    step_t s;
    int cyc;
    build(o, f, z, fw, mw, ret);
    op = o; funct = f; alu_zero = z; cyc = 0;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      mem_ready = s.rdy;
      @(negedge clk);
      chk_ctl($sformatf("op=%b fn=%b fw=%0d mw=%0d cyc%0d", o, f, fw, mw, cyc), s.val, s.care);
      @(posedge clk); #1;
      cyc++;
    end
    if (ret) cnt_model = (cnt_model + 1) % CNT_MOD;
    chk_int($sformatf("instr_cnt after op=%b", o), int'(instr_cnt), cnt_model);
  endtask

  // ---------------- directed table ----------------
  task automatic run_vec(input int idx, input vec_t t);
    ctl_t val, care;
    op = t.op; funct = t.funct; alu_zero = t.zero;
    for (int i = 0; i < t.lat; i++) begin
      mem_ready = t.rdy[i];
      @(negedge clk);
      if (i == 0) begin
        val = '0; care = '0;
        val.mem_re = 1; care.mem_re = 1; care.iord = 1; val.alusrcb = 2'd1; care.alusrcb = '1;
        care.alusrca = 1;
        chk_ctl($sformatf("vec%0d fetch", idx), val, care);
      end
      if (i == t.lat - 1) begin
        val = '0; care = '0;
        {val.pc_we, val.mem_we, val.reg_we, val.illegal, val.bus_err} = t.en;
        {care.pc_we, care.mem_we, care.reg_we, care.illegal, care.bus_err} = '1;
        care.mem_re = 1; care.ir_we = 1;
        {val.pc_src, val.reg_dst, val.mem_to_reg} = t.sel;
        {care.pc_src, care.reg_dst, care.mem_to_reg} = t.sel_care;
        chk_ctl($sformatf("vec%0d last", idx), val, care);
      end
      @(posedge clk); #1;
    end
    cnt_model = (cnt_model + t.dcnt) % CNT_MOD;
    chk_int($sformatf("vec%0d instr_cnt", idx), int'(instr_cnt), cnt_model);
  endtask

  vec_t tbl[13];

  initial begin
    ctl_t zero_c, en_c;
    logic [5:0] ro, rf;

    fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    alu_tab = '{4'b1000,   4'b0110,   4'b0000,   4'b0001,   4'b0111,   4'b1100};

    tbl[0]  = '{C_R,    6'b100000, 1'b0, 8'hFF,        4, 5'b00100, 4'b0010, 4'b0011, 1};
    tbl[1]  = '{C_R,    6'b100010, 1'b0, 8'hFF,        4, 5'b00100, 4'b0010, 4'b0011, 1};
    tbl[2]  = '{C_LW,   6'b000000, 1'b0, 8'b1110_0111, 7, 5'b00100, 4'b0001, 4'b0011, 1};
    tbl[3]  = '{C_SW,   6'b000000, 1'b0, 8'hFF,        4, 5'b01000, 4'b0000, 4'b0000, 1};
    tbl[4]  = '{C_BEQ,  6'b000000, 1'b1, 8'hFF,        3, 5'b10000, 4'b0100, 4'b1100, 1};
    tbl[5]  = '{C_BEQ,  6'b000000, 1'b0, 8'hFF,        3, 5'b00000, 4'b0100, 4'b1100, 1};
    tbl[6]  = '{C_J,    6'b000000, 1'b0, 8'hFF,        3, 5'b10000, 4'b1000, 4'b1100, 1};
    tbl[7]  = '{C_ADDI, 6'b000000, 1'b0, 8'hFF,        4, 5'b00100, 4'b0000, 4'b0011, 1};
    tbl[8]  = '{6'b111111, 6'b100000, 1'b0, 8'hFF,     2, 5'b00010, 4'b0000, 4'b0000, 0};
    tbl[9]  = '{C_R,    6'b000000, 1'b0, 8'hFF,        3, 5'b00010, 4'b0000, 4'b0000, 0};
    tbl[10] = '{C_J,    6'b000000, 1'b0, 8'b1111_1110, 4, 5'b10000, 4'b1000, 4'b1100, 1};
    tbl[11] = '{C_J,    6'b000000, 1'b0, 8'h00,        3, 5'b00001, 4'b0000, 4'b0000, 0};
    tbl[12] = '{C_SW,   6'b000000, 1'b0, 8'b1111_0111, 5, 5'b01000, 4'b0000, 4'b0000, 1};

    // Reset: enables low even with mem_ready high, counter cleared
    rst_n = 1'b0; op = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b1;
    clr(); en_c = c; zero_c = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_ctl("reset outputs", zero_c, en_c);
    chk_int("reset instr_cnt", int'(instr_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(i, tbl[i]);

    // EXEC alu_ctr for add, and memory timeouts in each memory state
    run_instr(C_R, 6'b100000, 1'b0, 0, 0);
    run_instr(C_J, 6'b000000, 1'b0, 3, 0);
    run_instr(C_LW, 6'b000000, 1'b0, 2, 2);
    run_instr(C_LW, 6'b000000, 1'b0, 0, 3);
    run_instr(C_SW, 6'b000000, 1'b0, 1, 5);

    // Reset asserted mid-MEMWR aborts the store combinationally
    op = C_SW; funct = '0; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    v = '0; c = '0; v.mem_we = 1; c.mem_we = 1; v.iord = 1; c.iord = 1;
    chk_ctl("memwr before reset", v, c);
    rst_n = 1'b0;
    #1;
    chk_ctl("memwr under reset", zero_c, en_c);
    chk_int("instr_cnt under reset", int'(instr_cnt), 0);
    cnt_model = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_instr(C_J, 6'b000000, 1'b0, 0, 0);

    // Counter wrap: reach all-ones then one more jump
    for (int i = 0; i < CNT_MOD && cnt_model != CNT_MOD - 1; i++)
      run_instr(C_J, 6'b000000, 1'b0, 0, 0);
    chk_int("instr_cnt all ones", int'(instr_cnt), CNT_MOD - 1);
    run_instr(C_J, 6'b000000, 1'b0, 0, 0);
    chk_int("instr_cnt wrap", int'(instr_cnt), 0);

    // Random instruction stream
    for (int n = 0; n < 200; n++) begin
      int fw, mw;
      case ($urandom_range(0, 7))
        0: ro = C_R;
        1: ro = C_LW;
        2: ro = C_SW;
        3: ro = C_BEQ;
        4: ro = C_ADDI;
        5: ro = C_J;
        default: ro = 6'($urandom);
      endcase
      if ($urandom_range(0, 3) != 0) rf = fn_tab[$urandom_range(0, 5)];
      else rf = 6'($urandom);
      fw = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 1)) : int'($urandom_range(0, TO - 1));
      mw = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 1)) : int'($urandom_range(0, TO - 1));
      run_instr(ro, rf, 1'($urandom_range(0, 1)), fw, mw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
